coproc_sequencer: RTL and testbench

COPROC_SEQUENCER -- requirements
Module: coproc_sequencer

---
 rtl/coproc_sequencer.sv | 144 ++++++++++++++
 tb/tb_coproc_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coproc_sequencer.sv
// Coprocessor job sequencer: store, compute, fetch, send.
// One job at a time with per-state timeout and sticky error flags.
module coproc_sequencer #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             rx_complete,
  input  logic             busy,
  input  logic             fpu_complete,
  input  logic             tx_complete,
  input  logic             clr_err,
  output logic             mem_wen,
  output logic             mem_ren,
  output logic             fpu_start,
  output logic             op,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] job_count,
  output logic             timeout_err,
  output logic             overrun_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STORE   = 3'd1,
    COMPUTE = 3'd2,
    FETCH   = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5,
    ERROR   = 3'd6,
    BAD     = 3'd7
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t           st_q;
  state_t           st_d;
  logic [TW-1:0]    tcnt_q;
  logic [TW-1:0]    tcnt_d;
  logic             f1_q;
  logic             f2_q;
  logic             busy_q;
  logic [CNT_W-1:0] jc_q;
  logic             terr_q;
  logic             oerr_q;
  logic             fall;
  logic             at_lim;
  logic             timed;
  logic             tmo;
  logic             done;

  // f1 is the sampled level, f2 its history; a fall is 1 -> 0
  assign fall   = f2_q & ~f1_q;
  assign at_lim = (tcnt_q == T_LAST);
  assign timed  = (st_q == COMPUTE) ||
                  (st_q == SEND) ||
                  (st_q == WAIT_TX);

  always_comb begin
    st_d = st_q;
    tmo  = 1'b0;
    done = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (rx_complete) st_d = STORE;
      end
      STORE: begin
        st_d = COMPUTE;
      end
      COMPUTE: begin
        if (fall) st_d = FETCH;
        else if (at_lim) tmo = 1'b1;
      end
      FETCH: begin
        st_d = SEND;
      end
      SEND: begin
        if (!busy_q) st_d = WAIT_TX;
        else if (at_lim) tmo = 1'b1;
      end
      WAIT_TX: begin
        if (tx_complete) begin
          st_d = IDLE;
          done = 1'b1;
        end else if (at_lim) begin
          tmo = 1'b1;
        end
      end
      ERROR: begin
        if (clr_err) st_d = IDLE;
      end
      BAD: begin
        st_d = IDLE;
      end
    endcase
    if (tmo) st_d = ERROR;
  end

  always_comb begin
    tcnt_d = '0;
    if (timed && (st_d == st_q))
      tcnt_d = tcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q   <= IDLE;
      tcnt_q <= '0;
      f1_q   <= 1'b0;
      f2_q   <= 1'b0;
      busy_q <= 1'b0;
      jc_q   <= '0;
      terr_q <= 1'b0;
      oerr_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      tcnt_q <= tcnt_d;
      f1_q   <= fpu_complete;
      f2_q   <= f1_q;
      busy_q <= busy;
      if (done) jc_q <= jc_q + 1'b1;
      if (tmo) terr_q <= 1'b1;
      else if (clr_err) terr_q <= 1'b0;
      if (rx_complete && (st_q != IDLE))
        oerr_q <= 1'b1;
      else if (clr_err)
        oerr_q <= 1'b0;
    end
  end

  // op follows the registered busy so no input reaches an output
  assign mem_wen     = (st_q == STORE);
  assign mem_ren     = (st_q == FETCH);
  assign fpu_start   = (st_q == COMPUTE) &&
                       (tcnt_q == '0);
  assign op          = (st_q == SEND) && !busy_q;
  assign state       = st_q;
  assign job_count   = jc_q;
  assign timeout_err = terr_q;
  assign overrun_err = oerr_q;

endmodule

// File: tb/tb_coproc_sequencer.sv
// Bench for coproc_sequencer: vector table, directed corner
// sequences and random traffic against a behavioural model.
module tb_coproc_sequencer;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_complete = 1'b0;
  logic       busy = 1'b0;
  logic       fpu_complete = 1'b0;
  logic       tx_complete = 1'b0;
  logic       clr_err = 1'b0;
  logic       mem_wen;
  logic       mem_ren;
  logic       fpu_start;
  logic       op;
  logic [2:0] state;
  logic [1:0] job_count;
  logic       timeout_err;
  logic       overrun_err;

  int total = 0;
  int bad = 0;

  coproc_sequencer #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .rx_complete(rx_complete),
    .busy(busy),
    .fpu_complete(fpu_complete),
    .tx_complete(tx_complete),
    .clr_err(clr_err),
    .mem_wen(mem_wen),
    .mem_ren(mem_ren),
    .fpu_start(fpu_start),
    .op(op),
    .state(state),
    .job_count(job_count),
    .timeout_err(timeout_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase number, age in phase, sample history
  int m_ph;
  int m_age;
  int m_jobs;
  bit m_terr;
  bit m_oerr;
  bit m_bl;
  bit m_h[$];

  function automatic void model_reset();
    m_ph = 0;
    m_age = 0;
    m_jobs = 0;
    m_terr = 0;
    m_oerr = 0;
    m_bl = 0;
    m_h = '{0, 0};
  endfunction

  function automatic void model_step(input bit rx, bz,
                                     input bit fp, tx, clr);
    int nx;
    bit fall;
    bit lim;
    bit tmo;
    fall = m_h[0] && !m_h[1];
    lim = (m_age == TMO - 1);
    nx = m_ph;
    tmo = 0;
    case (m_ph)
      0: if (rx) nx = 1;
      1: nx = 2;
      2: if (fall) nx = 3; else if (lim) tmo = 1;
      3: nx = 4;
      4: if (!m_bl) nx = 5; else if (lim) tmo = 1;
      5: if (tx) begin
           nx = 0;
           m_jobs++;
         end else if (lim) tmo = 1;
      6: if (clr) nx = 0;
      default: nx = 0;
    endcase
    if (tmo) nx = 6;
    if (tmo) m_terr = 1;
    else if (clr) m_terr = 0;
    if (rx && m_ph != 0) m_oerr = 1;
    else if (clr) m_oerr = 0;
    if (nx != m_ph) m_age = 0;
    else if (nx == 2 || nx == 4 || nx == 5) m_age++;
    else m_age = 0;
    m_ph = nx;
    void'(m_h.pop_front());
    m_h.push_back(fp);
    m_bl = bz;
  endfunction

  function automatic logic [10:0] model_vec();
    return {3'(m_ph), m_ph == 1, m_ph == 3,
            (m_ph == 2) && (m_age == 0),
            (m_ph == 4) && !m_bl,
            m_terr, m_oerr, 2'(m_jobs % 4)};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {state, mem_wen, mem_ren, fpu_start, op,
            timeout_err, overrun_err, job_count};
  endfunction

  task automatic tick(input bit rx, bz, fp, tx, clr);
    rx_complete = rx;
    busy = bz;
    fpu_complete = fp;
    tx_complete = tx;
    clr_err = clr;
    @(posedge clk);
    model_step(rx, bz, fp, tx, clr);
    #1;
    chk("model", dut_vec(), model_vec());
    chk("onehot",
        $onehot0({mem_wen, mem_ren, fpu_start, op}), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rx_complete = 0;
    busy = 0;
    fpu_complete = 0;
    tx_complete = 0;
    clr_err = 0;
    resetn = 0;
    #1;
    model_reset();
    chk("rst_vec", dut_vec(), 11'd0);
    @(posedge clk);
    #1;
    resetn = 1;
  endtask

  typedef struct {
    bit rx, bz, fp, tx, clr;
    bit [2:0] st;
    bit wen, ren, fs, op;
    bit [1:0] jc;
  } vec_t;

  vec_t tab[9];

  task automatic run_table();
    tab[0] = '{1,0,0,0,0, 3'd1, 1,0,0,0, 2'd0};
    tab[1] = '{0,0,1,0,0, 3'd2, 0,0,1,0, 2'd0};
    tab[2] = '{0,0,1,0,0, 3'd2, 0,0,0,0, 2'd0};
    tab[3] = '{0,0,0,0,0, 3'd2, 0,0,0,0, 2'd0};
    tab[4] = '{0,1,0,0,0, 3'd3, 0,1,0,0, 2'd0};
    tab[5] = '{0,1,0,0,0, 3'd4, 0,0,0,0, 2'd0};
    tab[6] = '{0,0,0,0,0, 3'd4, 0,0,0,1, 2'd0};
    tab[7] = '{0,0,0,0,0, 3'd5, 0,0,0,0, 2'd0};
    tab[8] = '{0,0,0,1,0, 3'd0, 0,0,0,0, 2'd1};
    for (int i = 0; i < 9; i++) begin
      tick(tab[i].rx, tab[i].bz, tab[i].fp,
           tab[i].tx, tab[i].clr);
      chk($sformatf("tab%0d", i),
          {state, mem_wen, mem_ren, fpu_start, op,
           job_count},
          {tab[i].st, tab[i].wen, tab[i].ren,
           tab[i].fs, tab[i].op, tab[i].jc});
    end
  endtask

  task automatic scn_nominal();
    int o;
    int j;
    j = (m_jobs + 1) % 4;
    for (int c = 0; c < 32; c++) begin
      tick(c == 10, 0, c >= 12 && c <= 20, c == 30, 0);
      o = c + 1;
      chk("nom_wen", mem_wen, o == 11);
      chk("nom_fs", fpu_start, o == 12);
      chk("nom_ren", mem_ren, o == 23);
      chk("nom_op", op, o == 24);
      if (o == 31) chk("nom_idle", state, 0);
    end
    chk("nom_jc", job_count, j);
  endtask

  task automatic scn_busy();
    int o;
    for (int c = 0; c < 34; c++) begin
      tick(c == 10, c >= 23 && c <= 27,
           c >= 12 && c <= 20, c == 32, 0);
      o = c + 1;
      chk("bsy_wen", mem_wen, o == 11);
      chk("bsy_fs", fpu_start, o == 12);
      chk("bsy_ren", mem_ren, o == 23);
      chk("bsy_op", op, o == 29);
      if (o == 28) chk("bsy_send", state, 4);
      if (o == 33) chk("bsy_idle", state, 0);
    end
  endtask

  task automatic scn_timeout();
    int o;
    for (int c = 0; c < 35; c++) begin
      tick(c == 10, 0, c >= 12 && c <= 31, 0, c == 31);
      o = c + 1;
      chk("tmo_ren", mem_ren, 0);
      chk("tmo_op", op, 0);
      if (o == 27) chk("tmo_pre", state, 2);
      if (o == 28) chk("tmo_err_st", state, 6);
      if (o >= 28 && o <= 31) chk("tmo_flag", timeout_err, 1);
      if (o == 32) chk("tmo_clr_st", state, 0);
      if (o == 32) chk("tmo_clr_fl", timeout_err, 0);
      if (o == 35) chk("tmo_late_fall", state, 0);
    end
  endtask

  task automatic scn_exit_wins();
    int o;
    for (int c = 0; c < 34; c++) begin
      tick(c == 10, 0, c >= 12 && c <= 25, c == 31, 0);
      o = c + 1;
      chk("ew_terr", timeout_err, 0);
      chk("ew_ren", mem_ren, o == 28);
      chk("ew_op", op, o == 29);
      if (o == 27) chk("ew_last", state, 2);
      if (o == 32) chk("ew_idle", state, 0);
    end
  endtask

  task automatic scn_overrun();
    int o;
    int j;
    j = (m_jobs + 1) % 4;
    for (int c = 0; c < 35; c++) begin
      tick(c == 10 || c == 15 || c == 25, 0,
           c >= 12 && c <= 20, c == 30,
           c == 25 || c == 33);
      o = c + 1;
      chk("ovr_flag", overrun_err, o >= 16 && o < 34);
      chk("ovr_ren", mem_ren, o == 23);
      chk("ovr_op", op, o == 24);
      if (o == 16) chk("ovr_st", state, 2);
      if (o == 31) chk("ovr_idle", state, 0);
    end
    chk("ovr_jc", job_count, j);
  endtask

  task automatic quick_job(input int last);
    for (int c = 0; c <= last; c++)
      tick(c == 0, 0, c == 1 || c == 2, c == 7, 0);
  endtask

  task automatic scn_wrap();
    logic [1:0] exp_jc [4];
    exp_jc[0] = 2'd1;
    exp_jc[1] = 2'd2;
    exp_jc[2] = 2'd3;
    exp_jc[3] = 2'd0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      quick_job(8);
      chk($sformatf("wrap%0d", k), job_count, exp_jc[k]);
    end
    quick_job(8);
    quick_job(6);
    chk("wtx_state", state, 5);
    #3;
    resetn = 0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_jc", job_count, 0);
    chk("arst_vec", dut_vec(), 11'd0);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1;
    tick(0, 0, 0, 0, 0);
    chk("post_rst", state, 0);
  endtask

  task automatic scn_random();
    bit fp;
    fp = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      if ($urandom_range(5) == 0) fp = ~fp;
      tick($urandom_range(7) == 0,
           $urandom_range(2) == 0, fp,
           $urandom_range(3) == 0,
           $urandom_range(15) == 0);
    end
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_init", dut_vec(), 11'd0);
    do_reset();
    run_table();
    scn_nominal();
    scn_busy();
    scn_timeout();
    scn_exit_wins();
    scn_overrun();
    scn_wrap();
    scn_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
